// File: rtl/arb_mux4to1.sv
// arb_mux4to1: four valid/ready sources merged into one registered sink
// stream by round-robin arbitration; each word is tagged {sel1,sel0}.
module arb_mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             valid3,
  output logic             ready0,
  output logic             ready1,
  output logic             ready2,
  output logic             ready3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel0,
  output logic             sel1
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;

  logic [3:0]       vld_in;
  logic [1:0]       gnt;
  logic             found;
  logic             load;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] gnt_data;

  assign vld_in = {valid3, valid2, valid1, valid0};
  assign load   = !vld_q | out_ready;

  // Search starts just past the last grant and wraps back to it.
  always_comb begin
    found = 1'b0;
    gnt   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!found && vld_in[last_q + 2'(k)]) begin
        found = 1'b1;
        gnt   = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    gnt_data = in0;
    unique case (gnt)
      2'd0: gnt_data = in0;
      2'd1: gnt_data = in1;
      2'd2: gnt_data = in2;
      2'd3: gnt_data = in3;
    endcase
  end

  always_comb begin
    rdy = '0;
    if (load && !rst && found)
      rdy[gnt] = 1'b1;
  end

  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    sel_d  = sel_q;
    last_d = last_q;
    if (load) begin
      if (found) begin
        out_d  = gnt_data;
        vld_d  = 1'b1;
        sel_d  = gnt;
        last_d = gnt;
      end else begin
        vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      sel_q  <= 2'd0;
      last_q <= 2'd3;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

  assign ready0    = rdy[0];
  assign ready1    = rdy[1];
  assign ready2    = rdy[2];
  assign ready3    = rdy[3];
  assign out       = out_q;
  assign out_valid = vld_q;
  assign sel0      = sel_q[0];
  assign sel1      = sel_q[1];

endmodule
